// File: rtl/exu_lsu_pkg.sv
// exu_lsu_pkg: shared definitions for the execute-stage load/store unit.
//   - access-size encodings of lsu_op_i[1:0] and the op flag bit positions
//   - FSM state type
//   - lane-count and access-size helpers
package exu_lsu_pkg;

  localparam logic [1:0] LSU_SIZE_B = 2'd0;
  localparam logic [1:0] LSU_SIZE_H = 2'd1;
  localparam logic [1:0] LSU_SIZE_W = 2'd2;
  localparam logic [1:0] LSU_SIZE_D = 2'd3;

  localparam int LSU_OP_UNSIGNED_BIT = 2;
  localparam int LSU_OP_STORE_BIT    = 3;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_WAIT,
    LSU_DONE
  } lsu_state_e;

  // Byte lanes on a bus of the given width.
  function automatic int lsu_lanes(input int dw);
    return dw / 8;
  endfunction

  // Access size in bytes; a D access on a 32-bit bus is clamped to a word.
  function automatic logic [3:0] lsu_size_bytes(input logic [1:0] size, input int lanes);
    case (size)
      LSU_SIZE_B: return 4'd1;
      LSU_SIZE_H: return 4'd2;
      LSU_SIZE_W: return 4'd4;
      default:    return (lanes >= 8) ? 4'd8 : 4'd4;
    endcase
  endfunction

endpackage

// File: rtl/exu_lsu_align.sv
// lsu_align: combinational byte-lane steering for exu_lsu.
//   size, uns      access size and unsigned-load flag
//   off            byte offset within the bus word (aligned down to the size)
//   wdata          right-aligned store data
//   rdata          raw bus read data
//   sel            byte-lane strobes
//   wdata_lanes    store data steered onto its lanes, unit replicated elsewhere
//   rdata_ext      extracted and sign/zero-extended load data
module lsu_align
  import exu_lsu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [1:0]                 size,
  input  logic                       uns,
  input  logic [$clog2(DW/8)-1:0]    off,
  input  logic [DW-1:0]              wdata,
  input  logic [DW-1:0]              rdata,
  output logic [DW/8-1:0]            sel,
  output logic [DW-1:0]              wdata_lanes,
  output logic [DW-1:0]              rdata_ext
);

  localparam int LANES = lsu_lanes(DW);
  localparam int OFFW  = $clog2(LANES);

  logic [3:0]      nbytes;
  logic [3:0]      low;
  logic [OFFW-1:0] off_al;
  logic [DW-1:0]   rsh;

  assign nbytes = lsu_size_bytes(size, LANES);
  assign low    = nbytes - 4'd1;
  assign off_al = off & ~low[OFFW-1:0];
  assign rsh    = rdata >> {off_al, 3'b000};

  // Lane i carries store byte (i mod size); on the strobed lanes that is
  // exactly wdata shifted up by the offset.
  always_comb begin
    sel         = '0;
    wdata_lanes = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      sel[i] = (i >= 32'(off_al)) && (i < 32'(off_al) + 32'(nbytes));
      wdata_lanes[8*i +: 8] = wdata[8*(i & 32'(low)) +: 8];
    end
  end

  always_comb begin
    rdata_ext = rsh;
    case (size)
      LSU_SIZE_B: rdata_ext = uns ? DW'(rsh[7:0])  : DW'($signed(rsh[7:0]));
      LSU_SIZE_H: rdata_ext = uns ? DW'(rsh[15:0]) : DW'($signed(rsh[15:0]));
      LSU_SIZE_W: rdata_ext = uns ? DW'(rsh[31:0]) : DW'($signed(rsh[31:0]));
      default:    rdata_ext = rsh;
    endcase
  end

endmodule

// File: rtl/exu_lsu.sv
// exu_lsu: registered load/store unit between execute and the data-bus master.
// Optional build macro: LSU_MISALIGN_TRAP_EN (misaligned access completes at
// once with err=1 and no bus request; otherwise the address is aligned down).
//   clk, rst_n        clock, asynchronous active-low reset
//   lsu_req_i/op/addr/wdata   pipeline request, held while lsu_stall_o=1
//   lsu_stall_o       pipeline stall
//   lsu_rdata_o       extended load data, valid with lsu_reg_we_o
//   lsu_reg_we_o      one-cycle load writeback enable
//   lsu_done_o        one-cycle completion pulse, lsu_err_o qualifies it
//   bus_req_*         request channel (valid/ready, addr, wdata, we, sel)
//   bus_rsp_*         response channel (valid/ready, rdata, err)
module exu_lsu
  import exu_lsu_pkg::*;
#(
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lsu_req_i,
  input  logic [3:0]        lsu_op_i,
  input  logic [AW-1:0]     lsu_addr_i,
  input  logic [DW-1:0]     lsu_wdata_i,
  output logic              lsu_stall_o,
  output logic [DW-1:0]     lsu_rdata_o,
  output logic              lsu_reg_we_o,
  output logic              lsu_done_o,
  output logic              lsu_err_o,
  output logic              bus_req_valid_o,
  input  logic              bus_req_ready_i,
  output logic [AW-1:0]     bus_addr_o,
  output logic [DW-1:0]     bus_wdata_o,
  output logic              bus_we_o,
  output logic [DW/8-1:0]   bus_sel_o,
  input  logic              bus_rsp_valid_i,
  output logic              bus_rsp_ready_o,
  input  logic [DW-1:0]     bus_rdata_i,
  input  logic              bus_rsp_err_i
);

  localparam int LANES = lsu_lanes(DW);
  localparam int OFFW  = $clog2(LANES);
  localparam int TW    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  lsu_state_e       state_q, state_d;
  logic [3:0]       op_q;
  logic [AW-1:0]    addr_q;
  logic [DW-1:0]    wdata_q;
  logic [DW-1:0]    rdata_q;
  logic             err_q;
  logic             kill_q;
  logic [TW-1:0]    cnt_q;

  logic             timeout;
  logic             misalign;
  logic             done;
  logic [LANES-1:0] sel_al;
  logic [DW-1:0]    wdata_al;
  logic [DW-1:0]    rdata_ext;

  lsu_align #(.DW(DW)) u_align (
    .size        (op_q[1:0]),
    .uns         (op_q[LSU_OP_UNSIGNED_BIT]),
    .off         (addr_q[OFFW-1:0]),
    .wdata       (wdata_q),
    .rdata       (bus_rdata_i),
    .sel         (sel_al),
    .wdata_lanes (wdata_al),
    .rdata_ext   (rdata_ext)
  );

  assign timeout = (TIMEOUT_CYC != 0) && (cnt_q == TW'(TIMEOUT_CYC - 1));

`ifdef LSU_MISALIGN_TRAP_EN
  logic [3:0] req_low;
  assign req_low  = lsu_size_bytes(lsu_op_i[1:0], LANES) - 4'd1;
  assign misalign = |(lsu_addr_i[OFFW-1:0] & req_low[OFFW-1:0]);
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LSU_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE: if (lsu_req_i) state_d = misalign ? LSU_DONE : LSU_REQ;
      LSU_REQ:  if (bus_req_ready_i) state_d = LSU_WAIT;
      LSU_WAIT: if (bus_rsp_valid_i || timeout) state_d = LSU_DONE;
      LSU_DONE: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      kill_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        LSU_IDLE: begin
          if (lsu_req_i) begin
            op_q    <= lsu_op_i;
            addr_q  <= lsu_addr_i;
            wdata_q <= lsu_wdata_i;
            kill_q  <= 1'b0;
            err_q   <= misalign;
          end
        end
        LSU_REQ: begin
          cnt_q <= '0;
          if (!lsu_req_i) kill_q <= 1'b1;
        end
        LSU_WAIT: begin
          if (!lsu_req_i) kill_q <= 1'b1;
          if (bus_rsp_valid_i) begin
            rdata_q <= rdata_ext;
            err_q   <= bus_rsp_err_i;
          end else if (timeout) begin
            err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // A dropped request lets the bus transaction finish but hides completion.
  assign done = (state_q == LSU_DONE) && !kill_q;

  assign lsu_stall_o     = lsu_req_i && (state_q != LSU_DONE);
  assign lsu_rdata_o     = rdata_q;
  assign lsu_done_o      = done;
  assign lsu_err_o       = done && err_q;
  assign lsu_reg_we_o    = done && !err_q && !op_q[LSU_OP_STORE_BIT];

  assign bus_req_valid_o = (state_q == LSU_REQ);
  assign bus_addr_o      = bus_req_valid_o ? {addr_q[AW-1:OFFW], {OFFW{1'b0}}} : '0;
  assign bus_wdata_o     = bus_req_valid_o ? wdata_al : '0;
  assign bus_sel_o       = bus_req_valid_o ? sel_al : '0;
  assign bus_we_o        = bus_req_valid_o && op_q[LSU_OP_STORE_BIT];
  assign bus_rsp_ready_o = (state_q == LSU_IDLE) || (state_q == LSU_WAIT);

endmodule

// File: tb/tb_exu_lsu.sv
// tb_exu_lsu: drives a 64-bit and a 32-bit exu_lsu in lockstep with the same
// handshake timing and checks both against a transaction-level model.
// Honours LSU_MISALIGN_TRAP_EN the same way as the design.
module tb_exu_lsu;
  import exu_lsu_pkg::*;

  localparam int AW = 32;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          lsu_req;
  logic [3:0]    lsu_op;
  logic [AW-1:0] lsu_addr;
  logic [63:0]   lsu_wdata;
  logic          req_ready, rsp_valid, rsp_err;
  logic [63:0]   rdata64;
  logic [31:0]   rdata32;

  logic          stall64, rwe64, done64, err64, valid64, bwe64, rspr64;
  logic [63:0]   rd_o64, wd64;
  logic [AW-1:0] addr64;
  logic [7:0]    sel64;
  logic          stall32, rwe32, done32, err32, valid32, bwe32, rspr32;
  logic [31:0]   rd_o32, wd32;
  logic [AW-1:0] addr32;
  logic [3:0]    sel32;

  exu_lsu #(.DW(64), .AW(AW), .TIMEOUT_CYC(TO)) u_dut64 (
    .clk(clk), .rst_n(rst_n),
    .lsu_req_i(lsu_req), .lsu_op_i(lsu_op), .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata),
    .lsu_stall_o(stall64), .lsu_rdata_o(rd_o64), .lsu_reg_we_o(rwe64),
    .lsu_done_o(done64), .lsu_err_o(err64),
    .bus_req_valid_o(valid64), .bus_req_ready_i(req_ready), .bus_addr_o(addr64),
    .bus_wdata_o(wd64), .bus_we_o(bwe64), .bus_sel_o(sel64),
    .bus_rsp_valid_i(rsp_valid), .bus_rsp_ready_o(rspr64),
    .bus_rdata_i(rdata64), .bus_rsp_err_i(rsp_err)
  );

  exu_lsu #(.DW(32), .AW(AW), .TIMEOUT_CYC(TO)) u_dut32 (
    .clk(clk), .rst_n(rst_n),
    .lsu_req_i(lsu_req), .lsu_op_i(lsu_op), .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata[31:0]),
    .lsu_stall_o(stall32), .lsu_rdata_o(rd_o32), .lsu_reg_we_o(rwe32),
    .lsu_done_o(done32), .lsu_err_o(err32),
    .bus_req_valid_o(valid32), .bus_req_ready_i(req_ready), .bus_addr_o(addr32),
    .bus_wdata_o(wd32), .bus_we_o(bwe32), .bus_sel_o(sel32),
    .bus_rsp_valid_i(rsp_valid), .bus_rsp_ready_o(rspr32),
    .bus_rdata_i(rdata32), .bus_rsp_err_i(rsp_err)
  );

  typedef struct {
    bit            stall, valid, rsp_ready, done, err, reg_we, we, chk32;
    logic [AW-1:0] addr64, addr32;
    logic [7:0]    sel64;
    logic [3:0]    sel32;
    logic [63:0]   wd64, rd64;
    logic [31:0]   wd32, rd32;
  } exp_t;

  exp_t q[$];
  exp_t ce;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] lanemask(input logic [7:0] s);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{s[i]}};
    return m;
  endfunction

  // Reference: lanes from size/offset, extension from the raw read word.
  function automatic void lsu_model(input int lanes, input logic [3:0] op, input logic [AW-1:0] addr,
                                    input logic [63:0] wdata, input logic [63:0] rdata,
                                    output logic [AW-1:0] baddr, output logic [7:0] sel,
                                    output logic [63:0] wl, output logic [63:0] ext, output bit mis);
    int nb, off;
    logic [63:0] mask, v;
    nb = 1 << op[1:0];
    if (nb > lanes) nb = lanes;
    off = int'(addr % lanes);
    mis = (off % nb) != 0;
    off = off - (off % nb);
    baddr = addr & ~AW'(lanes - 1);
    sel = '0; wl = '0; mask = '0;
    for (int k = 0; k < nb; k++) begin
      sel[off+k] = 1'b1;
      wl[8*(off+k) +: 8] = wdata[8*k +: 8];
      mask[8*k +: 8] = 8'hFF;
    end
    v = (rdata >> (8*off)) & mask;
    if (!op[2] && v[8*nb-1]) v = v | ~mask;
    if (lanes == 4) v[63:32] = '0;
    ext = v;
  endfunction

  task automatic access(input logic [3:0] op, input logic [AW-1:0] addr, input logic [63:0] wd,
                        input logic [63:0] rd64_in, input logic [31:0] rd32_in, input bit rerr,
                        input int rdly, input int sdly, input bit do_kill);
    exp_t e;
    logic [AW-1:0] a64, a32;
    logic [7:0] s64, s32;
    logic [63:0] w64, w32, x64, x32;
    bit mis64, mis32, trap, tmo, fail, in_req, in_wait;
    int d, t_rsp, kill_c;
    lsu_model(8, op, addr, wd, rd64_in, a64, s64, w64, x64, mis64);
    lsu_model(4, op, addr, wd, {32'h0, rd32_in}, a32, s32, w32, x32, mis32);
    trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = mis64;
`endif
    tmo   = sdly >= TO;
    t_rsp = 2 + rdly + sdly;
    d     = trap ? 1 : (tmo ? 2 + rdly + TO : t_rsp + 1);
    fail  = trap || tmo || rerr;
    kill_c = (do_kill && !trap) ? $urandom_range(d - 1, 1) : 0;
    for (int c = 0; c <= d; c++) begin
      @(posedge clk); #1;
      in_req  = !trap && c >= 1 && c <= 1 + rdly;
      in_wait = !trap && c >= 2 + rdly && c < d;
      lsu_req   = !(kill_c > 0 && c >= kill_c);
      lsu_op    = op;
      lsu_addr  = addr;
      lsu_wdata = wd;
      req_ready = in_req ? (c == 1 + rdly) : 1'($urandom);
      rsp_valid = in_wait ? (!tmo && c == t_rsp) : 1'($urandom);
      rsp_err   = (c == t_rsp) ? rerr : 1'($urandom);
      rdata64   = (c == t_rsp) ? rd64_in : {$urandom, $urandom};
      rdata32   = (c == t_rsp) ? rd32_in : $urandom;
      e.stall     = lsu_req && (c != d);
      e.valid     = in_req;
      e.rsp_ready = (c == 0) || in_wait;
      e.done      = (c == d) && (kill_c == 0);
      e.err       = e.done && fail;
      e.reg_we    = e.done && !fail && !op[3];
      e.we        = op[3];
      e.chk32     = (op[1:0] != LSU_SIZE_D);
      e.addr64 = a64;  e.sel64 = s64;  e.wd64 = w64;  e.rd64 = x64;
      e.addr32 = a32;  e.sel32 = s32[3:0];  e.wd32 = w32[31:0];  e.rd32 = x32[31:0];
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n, input int late_at);
    exp_t e;
    e = '{default: '0};
    e.rsp_ready = 1'b1;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      lsu_req   = 1'b0;
      req_ready = 1'($urandom);
      rsp_valid = (late_at < 0) ? 1'($urandom) : (c == late_at);
      rsp_err   = 1'($urandom);
      rdata64   = {$urandom, $urandom};
      rdata32   = $urandom;
      q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      ce = q.pop_front();
      check("stall64", 64'(stall64), 64'(ce.stall));
      check("valid64", 64'(valid64), 64'(ce.valid));
      check("rsp_ready64", 64'(rspr64), 64'(ce.rsp_ready));
      check("done64", 64'(done64), 64'(ce.done));
      check("err64", 64'(err64), 64'(ce.err));
      check("reg_we64", 64'(rwe64), 64'(ce.reg_we));
      check("stall32", 64'(stall32), 64'(ce.stall));
      check("valid32", 64'(valid32), 64'(ce.valid));
      check("rsp_ready32", 64'(rspr32), 64'(ce.rsp_ready));
      check("done32", 64'(done32), 64'(ce.done));
      check("err32", 64'(err32), 64'(ce.err));
      check("reg_we32", 64'(rwe32), 64'(ce.reg_we));
      if (ce.valid) begin
        check("bus_addr64", 64'(addr64), 64'(ce.addr64));
        check("bus_sel64", 64'(sel64), 64'(ce.sel64));
        check("bus_we64", 64'(bwe64), 64'(ce.we));
        if (ce.we) check("bus_wdata64", wd64 & lanemask(sel64), ce.wd64);
        check("bus_addr32", 64'(addr32), 64'(ce.addr32));
        check("bus_we32", 64'(bwe32), 64'(ce.we));
        if (ce.chk32) begin
          check("bus_sel32", 64'(sel32), 64'(ce.sel32));
          if (ce.we) check("bus_wdata32", 64'(wd32) & lanemask({4'h0, sel32}), 64'(ce.wd32));
        end
      end
      if (ce.reg_we) begin
        check("rdata64", rd_o64, ce.rd64);
        if (ce.chk32) check("rdata32", 64'(rd_o32), 64'(ce.rd32));
      end
    end
  end

  logic [AW-1:0] m_a;
  logic [7:0]    m_s;
  logic [63:0]   m_w, m_x;
  bit            m_mis;
  logic [3:0]    r_op;
  logic [AW-1:0] r_addr;
  int            r_sd;

  initial begin
    lsu_req = 1'b0; lsu_op = '0; lsu_addr = '0; lsu_wdata = '0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_err = 1'b0; rdata64 = '0; rdata32 = '0;

    // Model pinned to hand-computed values.
    lsu_model(4, 4'b1000, 32'h1003, 64'hA5, 64'h0, m_a, m_s, m_w, m_x, m_mis);
    check("model_sb_sel", 64'(m_s), 64'h08);
    check("model_sb_wdata", m_w, 64'hA500_0000);
    lsu_model(4, 4'b0001, 32'h2002, 64'h0, 64'h8001_1234, m_a, m_s, m_w, m_x, m_mis);
    check("model_lh", m_x, 64'hFFFF_8001);
    lsu_model(4, 4'b0101, 32'h2002, 64'h0, 64'h8001_1234, m_a, m_s, m_w, m_x, m_mis);
    check("model_lhu", m_x, 64'h0000_8001);
    lsu_model(8, 4'b0011, 32'h08, 64'h0, 64'h0, m_a, m_s, m_w, m_x, m_mis);
    check("model_ld_sel", 64'(m_s), 64'hFF);
    lsu_model(8, 4'b0010, 32'h0C, 64'h0, 64'h8000_0000_0000_0000, m_a, m_s, m_w, m_x, m_mis);
    check("model_lw64", m_x, 64'hFFFF_FFFF_8000_0000);
    lsu_model(4, 4'b0010, 32'h1, 64'h0, 64'h0, m_a, m_s, m_w, m_x, m_mis);
    check("model_lw_mis_addr", 64'(m_a), 64'h0);
    check("model_lw_mis_sel", 64'(m_s), 64'h0F);

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_stall", {stall64, stall32}, 2'b00);
    check("rst_valid", {valid64, valid32}, 2'b00);
    check("rst_done", {done64, done32, err64, err32, rwe64, rwe32}, 6'b0);
    check("rst_bus", {addr64, addr32, sel64, sel32, bwe64, bwe32}, '0);
    check("rst_rdata", rd_o64 | 64'(rd_o32) | wd64 | 64'(wd32), 64'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Directed cases.
    access(4'b1000, 32'h1003, 64'hA5, 64'h0, 32'h0, 1'b0, 0, 0, 1'b0);
    access(4'b0001, 32'h2002, 64'h0, 64'h0000_0000_8001_1234, 32'h8001_1234, 1'b0, 0, 0, 1'b0);
    access(4'b0101, 32'h2002, 64'h0, 64'h0000_0000_8001_1234, 32'h8001_1234, 1'b0, 0, 1, 1'b0);
    access(4'b0010, 32'h100, 64'h0, 64'h1234_5678_9ABC_DEF0, 32'h9ABC_DEF0, 1'b0, 5, 1, 1'b0);
    access(4'b0010, 32'h200, 64'h0, 64'h0, 32'h0, 1'b0, 0, 20, 1'b0);
    idle(5, 2);
    access(4'b0011, 32'h08, 64'h0, 64'hFEDC_BA98_7654_3210, 32'h7654_3210, 1'b0, 1, 0, 1'b0);
    access(4'b0010, 32'h0C, 64'h0, 64'h8000_0000_0000_0000, 32'h8000_0000, 1'b0, 0, 0, 1'b0);
    access(4'b0010, 32'h1, 64'h0, 64'h0000_0000_1111_2222, 32'h1111_2222, 1'b0, 0, 0, 1'b0);
    access(4'b1010, 32'h44, 64'hCAFE_F00D, 64'h0, 32'h0, 1'b1, 2, 15, 1'b0);
    access(4'b0000, 32'h45, 64'h0, 64'h0, 32'h0, 1'b0, 1, 2, 1'b1);
    idle(1, -1);

    // Reset in the middle of a request.
    @(posedge clk); #1;
    lsu_req = 1'b1; lsu_op = 4'b0010; lsu_addr = 32'h40; req_ready = 1'b0; rsp_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_valid", {valid64, valid32}, 2'b11);
    lsu_req = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {valid64, valid32, done64, done32}, 4'b0);
    check("mid_rst_sel", {sel64, sel32}, 12'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    access(4'b0110, 32'h0A, 64'h0, 64'h0000_8765_0000_0000, 32'h0000_8765, 1'b0, 0, 0, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      r_op   = 4'($urandom);
      r_addr = $urandom;
      if (r_op[1:0] == LSU_SIZE_D) r_addr[2:0] = 3'b000;
      r_sd = ($urandom_range(9, 0) == 0) ? $urandom_range(18, 14) : $urandom_range(4, 0);
      access(r_op, r_addr, {$urandom, $urandom}, {$urandom, $urandom}, $urandom,
             ($urandom_range(7, 0) == 0), $urandom_range(3, 0), r_sd,
             ($urandom_range(9, 0) == 0));
      idle($urandom_range(2, 0), -1);
    end
    idle(2, -1);
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
